// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 keyboard event path: scan-code prefix and
// error bytes, the 10-bit key event record and the controller state
// encoding. Imported by key_evt_fifo and ps2_key_event_ctrl.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_ERR0      = 8'h00;
    localparam logic [7:0] PS2_ERR1      = 8'hFF;

    localparam int KEY_EVT_W = 10;

    // Packed so it maps bit-exactly onto the {release, extended, code} bus.
    typedef struct packed {
        logic       is_release;
        logic       extended;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_PARSE   = 3'd3,
        ST_SKIP    = 3'd4,
        ST_RECOVER = 3'd5
    } ctrl_state_e;

    function automatic key_evt_t make_evt(input logic rel, input logic ext,
                                          input logic [7:0] code);
        key_evt_t e;
        e.is_release = rel;
        e.extended   = ext;
        e.code       = code;
        return e;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo
// Small synchronous FIFO for MMIO event sources.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   push/push_data write request and entry
//   pop            consumer takes the head entry (ignored when empty)
//   head_data      head entry, forced to 0 while empty
//   full, empty    occupancy flags
// A push and a pop in the same cycle are both honoured, also when full.
// A push while empty lands next cycle (no bypass). A push while full
// without a pop is discarded; the caller sees that through full.
module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        // When full, the slot under the write pointer is the head being
        // popped this same cycle, so overwriting it is safe.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is carried by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Sequences a ps2_keyboard receiver: pops bytes through the ready /
// nextdata_n handshake, decodes E0/F0/E1 prefixes, tracks held keys and
// queues {release, extended, code} events for a valid/ready consumer.
// Receiver overflow triggers a one-cycle rx_clear pulse.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   en                  allow byte draining (0 holds the receiver)
//   rx_data/rx_ready    receiver byte and byte-available flag
//   rx_overflow         receiver overflow flag
//   rx_nextdata_n       active-low pop strobe to receiver
//   rx_clear            one-cycle reset pulse to receiver
//   evt_valid/ready     event handshake, evt_data = {release, ext, code}
//   drop_cnt            events lost to a full queue, saturating
//   held_any            some key is held (one cycle behind the table)
// Build option: define KBD_REPEAT_FILTER_EN to suppress typematic repeats
// (a make whose key is already held is not queued).
module ps2_key_event_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_overflow,
    output logic       rx_nextdata_n,
    output logic       rx_clear,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [9:0] evt_data,
    output logic [7:0] drop_cnt,
    output logic       held_any
);

    ctrl_state_e  state_q, state_d;
    logic [7:0]   byte_q, byte_d;
    logic         ext_q, ext_d;
    logic         brk_q, brk_d;
    logic [7:0]   skip_q, skip_d;
    logic [511:0] held_q, held_d;
    logic         held_any_q, held_any_d;
    logic [7:0]   drop_q, drop_d;
    logic         nextdata_n_q, nextdata_n_d;
    logic         clear_q, clear_d;

    logic         push;
    key_evt_t     push_evt;
    logic [8:0]   held_idx;
    logic         fifo_full;
    logic         fifo_empty;
    logic [9:0]   fifo_head;

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        held_d   = held_q;
        push     = 1'b0;
        push_evt = '0;
        held_idx = {ext_q, byte_q};

        case (state_q)
            ST_IDLE: begin
                if (en && rx_ready && !rx_overflow) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                byte_d  = rx_data;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // A nonzero skip count means this byte belongs to a Pause
                // sequence: count it off instead of parsing it.
                if (skip_q != 8'd0) begin
                    skip_d  = skip_q - 8'd1;
                    state_d = ST_SKIP;
                end else begin
                    state_d = ST_PARSE;
                end
            end
            ST_PARSE: begin
                state_d = ST_IDLE;
                case (byte_q)
                    PS2_PFX_EXT: ext_d = 1'b1;
                    PS2_PFX_BRK: brk_d = 1'b1;
                    PS2_PFX_PAUSE: begin
                        skip_d  = 8'(PAUSE_SKIP);
                        state_d = ST_SKIP;
                    end
                    PS2_ERR0, PS2_ERR1: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        held_d[held_idx] = ~brk_q;
                        push_evt         = make_evt(brk_q, ext_q, byte_q);
`ifdef KBD_REPEAT_FILTER_EN
                        push = brk_q | ~held_q[held_idx];
`else
                        push = 1'b1;
`endif
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
            ST_SKIP: begin
                if (skip_q == 8'd0) begin
                    push     = 1'b1;
                    push_evt = make_evt(1'b0, 1'b0, PS2_PFX_PAUSE);
                    state_d  = ST_IDLE;
                end else if (en && rx_ready && !rx_overflow) begin
                    state_d = ST_POP;
                end
            end
            ST_RECOVER: begin
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                skip_d  = 8'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Overflow wins over every other transition. RECOVER itself always
        // leaves after one cycle so rx_clear stays a single pulse.
        if (rx_overflow && (state_q != ST_RECOVER)) begin
            state_d = ST_RECOVER;
        end

        held_any_d = |held_q;

        drop_d = drop_q;
        if (push && fifo_full && !evt_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        // Strobes are registered from the next state so they line up
        // exactly with the POP / RECOVER cycles.
        nextdata_n_d = (state_d != ST_POP);
        clear_d      = (state_d == ST_RECOVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= 8'd0;
            held_q       <= '0;
            held_any_q   <= 1'b0;
            drop_q       <= 8'd0;
            nextdata_n_q <= 1'b1;
            clear_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            skip_q       <= skip_d;
            held_q       <= held_d;
            held_any_q   <= held_any_d;
            drop_q       <= drop_d;
            nextdata_n_q <= nextdata_n_d;
            clear_q      <= clear_d;
        end
    end

    always_ff @(posedge clk) begin
        byte_q <= byte_d;
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_EVT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_nextdata_n = nextdata_n_q;
    assign rx_clear      = clear_q;
    assign evt_valid     = ~fifo_empty;
    assign evt_data      = fifo_head;
    assign drop_cnt      = drop_q;
    assign held_any      = held_any_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_overflow = 1'b0;
    logic       rx_nextdata_n;
    logic       rx_clear;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [9:0] evt_data;
    logic [7:0] drop_cnt;
    logic       held_any;

    int tests = 0;
    int fails = 0;

    ps2_key_event_ctrl #(.FIFO_DEPTH(8), .PAUSE_SKIP(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_overflow   (rx_overflow),
        .rx_nextdata_n (rx_nextdata_n),
        .rx_clear      (rx_clear),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_data      (evt_data),
        .drop_cnt      (drop_cnt),
        .held_any      (held_any)
    );

    always #5 clk = ~clk;

    // Receiver model: byte queue popped on a clock edge with nextdata_n low.
    logic [7:0] rx_mem [256];
    int rx_wr = 0;
    int rx_rd = 0;
    assign rx_ready = (rx_rd != rx_wr);
    assign rx_data  = rx_mem[rx_rd[7:0]];
    always @(posedge clk) begin
        if (!rx_nextdata_n && (rx_rd != rx_wr)) rx_rd <= rx_rd + 1;
    end

    // Consumer log of accepted events.
    logic [9:0] ev_log [256];
    int ev_n = 0;
    always @(posedge clk) begin
        if (evt_valid && evt_ready) begin
            ev_log[ev_n[7:0]] <= evt_data;
            ev_n <= ev_n + 1;
        end
    end

    typedef struct {
        int          nb;
        logic [79:0] bytes;
        int          ne;
        logic [39:0] evs;
        logic        held;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_mem[rx_wr[7:0]] = b;
        rx_wr++;
    endtask

    task automatic wait_drained();
        int k = 0;
        while ((rx_rd != rx_wr) && (k < 400)) begin
            @(posedge clk);
            k++;
        end
        if (rx_rd != rx_wr) begin
            tests++;
            fails++;
            $display("FAIL rx_drain_timeout: got %0d bytes left, expected 0", rx_wr - rx_rd);
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        vecs[0] = '{1, 80'h1C, 1, 40'h01C, 1'b1};
        vecs[1] = '{2, 80'({8'hF0, 8'h1C}), 1, 40'h21C, 1'b0};
        vecs[2] = '{2, 80'({8'hE0, 8'h75}), 1, 40'h175, 1'b1};
        vecs[3] = '{3, 80'({8'hE0, 8'hF0, 8'h75}), 1, 40'h375, 1'b0};
        vecs[4] = '{1, 80'h00, 0, 40'h0, 1'b0};
        vecs[5] = '{3, 80'({8'hF0, 8'hFF, 8'h1C}), 1, 40'h01C, 1'b1};
        vecs[6] = '{2, 80'({8'hF0, 8'h1C}), 1, 40'h21C, 1'b0};
`ifdef KBD_REPEAT_FILTER_EN
        vecs[7] = '{5, 80'({8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}), 2,
                    40'({10'h01C, 10'h21C}), 1'b0};
`else
        vecs[7] = '{5, 80'({8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}), 4,
                    40'({10'h01C, 10'h01C, 10'h01C, 10'h21C}), 1'b0};
`endif
        vecs[8] = '{9, 80'({8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C}),
                    2, 40'({10'h0E1, 10'h01C}), 1'b1};
        vecs[9] = '{2, 80'({8'hF0, 8'h1C}), 1, 40'h21C, 1'b0};

        // Reset values
        do_reset();
        check("rst_nextdata_n", 32'(rx_nextdata_n), 1);
        check("rst_rx_clear",   32'(rx_clear), 0);
        check("rst_evt_valid",  32'(evt_valid), 0);
        check("rst_evt_data",   32'(evt_data), 0);
        check("rst_drop_cnt",   32'(drop_cnt), 0);
        check("rst_held_any",   32'(held_any), 0);

        // Single make latency: valid appears on the 4th edge after rx_ready
        evt_ready = 1'b0;
        send_byte(8'h1C);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_valid_early", 32'(evt_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid", 32'(evt_valid), 1);
        check("lat_data", 32'(evt_data), 32'h01C);
        evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_drained", 32'(evt_valid), 0);

        // Table of byte sequences
        do_reset();
        for (int v = 0; v < 10; v++) begin
            base = ev_n;
            for (int i = 0; i < vecs[v].nb; i++)
                send_byte(vecs[v].bytes[8*(vecs[v].nb-1-i) +: 8]);
            wait_drained();
            check($sformatf("vec%0d_count", v), ev_n - base, vecs[v].ne);
            for (int i = 0; i < vecs[v].ne; i++)
                check($sformatf("vec%0d_evt%0d", v, i), 32'(ev_log[(base + i) % 256]),
                      32'(vecs[v].evs[10*(vecs[v].ne-1-i) +: 10]));
            check($sformatf("vec%0d_held_any", v), 32'(held_any), 32'(vecs[v].held));
        end

        // Overflow recovery after an E0 prefix
        base = ev_n;
        send_byte(8'hE0);
        wait_drained();
        rx_overflow = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovf_clear_pulse", 32'(rx_clear), 1);
        rx_overflow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ovf_clear_end", 32'(rx_clear), 0);
        send_byte(8'h74);
        wait_drained();
        check("ovf_count", ev_n - base, 1);
        check("ovf_evt", 32'(ev_log[base % 256]), 32'h074);

        // en low holds the receiver
        base = ev_n;
        en = 1'b0;
        send_byte(8'h1C);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("en_hold_byte", 32'(rx_ready), 1);
        check("en_hold_count", ev_n - base, 0);
        en = 1'b1;
        wait_drained();
        check("en_resume_count", ev_n - base, 1);
        check("en_resume_evt", 32'(ev_log[base % 256]), 32'h01C);

        // FIFO overflow: 11 makes into 8 entries
        evt_ready = 1'b0;
        base = ev_n;
        for (int i = 0; i < 11; i++) send_byte(8'h10 + 8'(i));
        wait_drained();
        check("full_valid", 32'(evt_valid), 1);
        check("full_drop_cnt", 32'(drop_cnt), 3);
        check("full_head", 32'(evt_data), 32'h010);
        evt_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_count", ev_n - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("drain_evt%0d", i), 32'(ev_log[(base + i) % 256]), 32'h010 + i);
        check("drain_valid", 32'(evt_valid), 0);

        // Reset in the middle of SETTLE
        evt_ready = 1'b0;
        send_byte(8'h1C);
        wait_drained();
        check("pre_rst_valid", 32'(evt_valid), 1);
        send_byte(8'h2A);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_nextdata_n", 32'(rx_nextdata_n), 1);
        check("mid_rst_rx_clear",   32'(rx_clear), 0);
        check("mid_rst_evt_valid",  32'(evt_valid), 0);
        check("mid_rst_evt_data",   32'(evt_data), 0);
        check("mid_rst_drop_cnt",   32'(drop_cnt), 0);
        check("mid_rst_held_any",   32'(held_any), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
